// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared load/store op encodings and memory-stage FSM states
package mem_pkg;

  localparam logic [3:0] LSU_NONE  = 4'd0;
  localparam logic [3:0] LSU_LD_B  = 4'd1;
  localparam logic [3:0] LSU_LD_H  = 4'd2;
  localparam logic [3:0] LSU_LD_W  = 4'd3;
  localparam logic [3:0] LSU_LD_BU = 4'd4;
  localparam logic [3:0] LSU_LD_HU = 4'd5;
  localparam logic [3:0] LSU_ST_B  = 4'd6;
  localparam logic [3:0] LSU_ST_H  = 4'd7;
  localparam logic [3:0] LSU_ST_W  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  function automatic logic lsu_is_load(input logic [3:0] op);
    return (op == LSU_LD_B) || (op == LSU_LD_H) || (op == LSU_LD_W) ||
           (op == LSU_LD_BU) || (op == LSU_LD_HU);
  endfunction

  function automatic logic lsu_is_store(input logic [3:0] op);
    return (op == LSU_ST_B) || (op == LSU_ST_H) || (op == LSU_ST_W);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store strobe/data lane generation, load extract/extend, misalignment detect
module lsu_align
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_load,
  output logic        is_store,
  output logic        misalign,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  // The bus returns the aligned word; the addressed byte/half is shifted down to bit 0.
  assign lane = rdata >> {addr_lo, 3'b000};

  always_comb begin
    is_load   = lsu_is_load(op);
    is_store  = lsu_is_store(op);
    is_mem    = is_load || is_store;
    misalign  = 1'b0;
    wstrb     = 4'b0000;
    wdata     = 32'h0;
    load_data = lane;
    case (op)
      LSU_LD_B:  load_data = {{24{lane[7]}}, lane[7:0]};
      LSU_LD_BU: load_data = {24'h0, lane[7:0]};
      LSU_LD_H: begin
        misalign  = addr_lo[0];
        load_data = {{16{lane[15]}}, lane[15:0]};
      end
      LSU_LD_HU: begin
        misalign  = addr_lo[0];
        load_data = {16'h0, lane[15:0]};
      end
      LSU_LD_W:  misalign = |addr_lo;
      LSU_ST_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      LSU_ST_H: begin
        misalign = addr_lo[0];
        wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store_data[15:0]}};
      end
      LSU_ST_W: begin
        misalign = |addr_lo;
        wstrb    = 4'hF;
        wdata    = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with one-at-a-time load/store bus port
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LSU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [31:0]             ex_pc,
  input  logic [31:0]             ex_inst,
  input  logic [DATA_WIDTH-1:0]   ex_result,
  input  logic [LSU_OP_WIDTH-1:0] ex_lsu_op,
  input  logic [DATA_WIDTH-1:0]   ex_lsu_data,
  input  logic                    ex_rw_en,
  input  logic [4:0]              ex_rw_addr,
  output logic                    dreq_valid,
  input  logic                    dreq_ready,
  output logic                    dreq_we,
  output logic [ADDR_WIDTH-1:0]   dreq_addr,
  output logic [3:0]              dreq_wstrb,
  output logic [DATA_WIDTH-1:0]   dreq_wdata,
  input  logic                    dresp_valid,
  input  logic [DATA_WIDTH-1:0]   dresp_rdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [31:0]             mem_pc,
  output logic [31:0]             mem_inst,
  output logic                    mem_rw_en,
  output logic [4:0]              mem_rw_addr,
  output logic [DATA_WIDTH-1:0]   mem_rw_data,
  output logic                    mem_ale
);

  mem_state_t state, state_nxt;

  logic [LSU_OP_WIDTH-1:0] req_op;
  logic [31:0]             req_pc;
  logic [31:0]             req_inst;
  logic [DATA_WIDTH-1:0]   req_result;
  logic                    req_rw_en;
  logic [4:0]              req_rw_addr;

  logic [LSU_OP_WIDTH-1:0] al_op;
  logic [1:0]              al_addr_lo;
  logic                    al_is_mem, al_is_load, al_is_store, al_misalign;
  logic [3:0]              al_wstrb;
  logic [31:0]             al_wdata, al_load_data;

  logic accept, go_mem, load_direct, resp_done;

  // In IDLE the aligner looks at the incoming op; afterwards at the latched one.
  assign al_op      = (state == IDLE) ? ex_lsu_op       : req_op;
  assign al_addr_lo = (state == IDLE) ? ex_result[1:0]  : req_result[1:0];

  lsu_align u_align (
    .op         (al_op),
    .addr_lo    (al_addr_lo),
    .store_data (ex_lsu_data),
    .rdata      (dresp_rdata),
    .is_mem     (al_is_mem),
    .is_load    (al_is_load),
    .is_store   (al_is_store),
    .misalign   (al_misalign),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load_data)
  );

  assign ex_ready    = (state == IDLE) && (!mem_valid || mem_ready);
  assign accept      = ex_valid && ex_ready;
  assign go_mem      = accept && al_is_mem && !al_misalign;
  assign load_direct = accept && !go_mem;
  assign resp_done   = (state == RESP) && dresp_valid;

  assign dreq_valid = (state == REQ);
  assign dreq_addr  = req_result;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_mem) state_nxt = REQ;
      REQ:     if (dreq_ready) state_nxt = RESP;
      RESP:    if (dresp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_op      <= '0;
      req_pc      <= '0;
      req_inst    <= '0;
      req_result  <= '0;
      req_rw_en   <= 1'b0;
      req_rw_addr <= '0;
      dreq_we     <= 1'b0;
      dreq_wstrb  <= '0;
      dreq_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_op      <= ex_lsu_op;
        req_pc      <= ex_pc;
        req_inst    <= ex_inst;
        req_result  <= ex_result;
        req_rw_en   <= ex_rw_en;
        req_rw_addr <= ex_rw_addr;
        dreq_we     <= al_is_store;
        dreq_wstrb  <= al_wstrb;
        dreq_wdata  <= al_wdata;
      end
    end
  end

  // Accept only happens with the output register empty or draining, so a
  // completing response always finds it free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid   <= 1'b0;
      mem_pc      <= '0;
      mem_inst    <= '0;
      mem_rw_en   <= 1'b0;
      mem_rw_addr <= '0;
      mem_rw_data <= '0;
      mem_ale     <= 1'b0;
    end else if (load_direct) begin
      mem_valid   <= 1'b1;
      mem_pc      <= ex_pc;
      mem_inst    <= ex_inst;
      mem_rw_en   <= al_is_mem ? 1'b0 : ex_rw_en;
      mem_rw_addr <= ex_rw_addr;
      mem_rw_data <= ex_result;
      mem_ale     <= al_misalign;
    end else if (resp_done) begin
      mem_valid   <= 1'b1;
      mem_pc      <= req_pc;
      mem_inst    <= req_inst;
      mem_rw_en   <= al_is_load ? req_rw_en : 1'b0;
      mem_rw_addr <= req_rw_addr;
      mem_rw_data <= al_is_load ? al_load_data : req_result;
      mem_ale     <= 1'b0;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - table-driven scoreboard bench for mem_stage
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_inst, ex_result, ex_lsu_data;
  logic [3:0]  ex_lsu_op;
  logic        ex_rw_en;
  logic [4:0]  ex_rw_addr;
  logic        dreq_valid, dreq_ready, dreq_we;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_wstrb;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic        mem_valid, mem_ready, mem_rw_en, mem_ale;
  logic [31:0] mem_pc, mem_inst, mem_rw_data;
  logic [4:0]  mem_rw_addr;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_result(ex_result), .ex_lsu_op(ex_lsu_op), .ex_lsu_data(ex_lsu_data),
    .ex_rw_en(ex_rw_en), .ex_rw_addr(ex_rw_addr),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
    .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc), .mem_inst(mem_inst),
    .mem_rw_en(mem_rw_en), .mem_rw_addr(mem_rw_addr), .mem_rw_data(mem_rw_data),
    .mem_ale(mem_ale)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, sdata, rdata;
    logic        rw_en;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_en, exp_ale, chk_data, req, we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } vec_t;

  typedef struct {
    logic [31:0] pc, inst, data;
    logic [4:0]  rd;
    logic        en, ale, chk_data;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   popped = 0;
  int   seq    = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input logic rw_en, input logic [4:0] rd,
                              input logic [31:0] exp_data, input logic exp_en, input logic exp_ale,
                              input logic chk_data, input logic req, input logic we,
                              input logic [3:0] wstrb, input logic [31:0] wdata);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.rw_en = rw_en; v.rd = rd;
    v.exp_data = exp_data; v.exp_en = exp_en; v.exp_ale = exp_ale; v.chk_data = chk_data;
    v.req = req; v.we = we; v.wstrb = wstrb; v.wdata = wdata;
    return v;
  endfunction

  // Scoreboard: every Writeback handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        chk("out_pc", mem_pc, e.pc);
        chk("out_inst", mem_inst, e.inst);
        chk("out_rw_en", {31'h0, mem_rw_en}, {31'h0, e.en});
        chk("out_rw_addr", {27'h0, mem_rw_addr}, {27'h0, e.rd});
        chk("out_ale", {31'h0, mem_ale}, {31'h0, e.ale});
        if (e.chk_data) chk("out_rw_data", mem_rw_data, e.data);
      end
    end
  end

  task automatic issue(input vec_t v, input int req_wait, input int out_stall);
    int   n;
    exp_t e;
    @(negedge clk);
    seq++;
    ex_valid    = 1'b1;
    ex_pc       = 32'h1c00_0000 + 32'(seq * 4);
    ex_inst     = 32'h0280_0000 | 32'(seq);
    ex_result   = v.addr;
    ex_lsu_op   = v.op;
    ex_lsu_data = v.sdata;
    ex_rw_en    = v.rw_en;
    ex_rw_addr  = v.rd;
    n = 0;
    while (!ex_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ex_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      ex_valid = 1'b0;
      return;
    end
    e.pc = ex_pc; e.inst = ex_inst; e.data = v.exp_data; e.rd = v.rd;
    e.en = v.exp_en; e.ale = v.exp_ale; e.chk_data = v.chk_data;
    sb.push_back(e);
    pushed++;
    @(posedge clk);
    #1;
    ex_valid  = 1'b0;
    ex_lsu_op = 4'($urandom_range(0, 8));
    ex_result = $urandom;
    if (out_stall > 0) mem_ready = 1'b0;
    @(negedge clk);
    if (v.req) begin
      chk("dreq_valid", {31'h0, dreq_valid}, 32'd1);
      chk("dreq_addr", dreq_addr, v.addr);
      chk("dreq_we", {31'h0, dreq_we}, {31'h0, v.we});
      chk("dreq_wstrb", {28'h0, dreq_wstrb}, {28'h0, v.wstrb});
      if (v.we) chk("dreq_wdata", dreq_wdata, v.wdata);
      for (int k = 0; k < req_wait; k++) begin
        chk("ex_ready_in_req", {31'h0, ex_ready}, 32'd0);
        dresp_valid = (k == 0);
        dresp_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        dresp_valid = 1'b0;
        chk("dreq_hold_valid", {31'h0, dreq_valid}, 32'd1);
        chk("dreq_hold_addr", dreq_addr, v.addr);
        chk("dreq_hold_wstrb", {28'h0, dreq_wstrb}, {28'h0, v.wstrb});
        if (v.we) chk("dreq_hold_wdata", dreq_wdata, v.wdata);
      end
      dreq_ready = 1'b1;
      @(posedge clk);
      #1;
      dreq_ready = 1'b0;
      @(negedge clk);
      chk("dreq_drop_in_resp", {31'h0, dreq_valid}, 32'd0);
      chk("ex_ready_in_resp", {31'h0, ex_ready}, 32'd0);
      dresp_valid = 1'b1;
      dresp_rdata = v.rdata;
      @(posedge clk);
      #1;
      dresp_valid = 1'b0;
      dresp_rdata = $urandom;
      @(negedge clk);
    end else begin
      chk("no_dreq", {31'h0, dreq_valid}, 32'd0);
    end
    chk("latency_mem_valid", {31'h0, mem_valid}, 32'd1);
    for (int k = 0; k < out_stall; k++) begin
      chk("stall_ex_ready", {31'h0, ex_ready}, 32'd0);
      chk("stall_mem_valid", {31'h0, mem_valid}, 32'd1);
      if (v.chk_data) chk("stall_rw_data", mem_rw_data, v.exp_data);
      @(negedge clk);
    end
    if (out_stall > 0) begin
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_pc = 0; ex_inst = 0; ex_result = 0; ex_lsu_op = LSU_NONE;
    ex_lsu_data = 0; ex_rw_en = 0; ex_rw_addr = 0; dreq_ready = 0; dresp_valid = 0;
    dresp_rdata = 0; mem_ready = 1'b1;

    //         op         addr          sdata         rdata         en rd  exp_data      en ale chk req we strb     wdata
    vecs.push_back(mk(LSU_NONE,  32'h0000_1234, 32'h0,        32'h0,        1, 5,  32'h0000_1234, 1, 0, 1, 0, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_LD_B,  32'h0000_1003, 32'h0,        32'h80FF_FFFF, 1, 6,  32'hFFFF_FF80, 1, 0, 1, 1, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_LD_BU, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 1, 7,  32'h0000_0080, 1, 0, 1, 1, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_ST_H,  32'h0000_2002, 32'h0000_ABCD, 32'h0,       1, 8,  32'h0000_2002, 0, 0, 1, 1, 1, 4'b1100, 32'hABCD_ABCD));
    vecs.push_back(mk(LSU_LD_W,  32'h0000_3001, 32'h0,        32'h0,        1, 9,  32'h0,         0, 1, 0, 0, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_LD_H,  32'h0000_4002, 32'h0,        32'h8001_1234, 1, 10, 32'hFFFF_8001, 1, 0, 1, 1, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_LD_HU, 32'h0000_4002, 32'h0,        32'h8001_1234, 1, 11, 32'h0000_8001, 1, 0, 1, 1, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_LD_W,  32'h0000_5000, 32'h0,        32'hDEAD_BEEF, 1, 12, 32'hDEAD_BEEF, 1, 0, 1, 1, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_ST_B,  32'h0000_6001, 32'h1234_56A5, 32'h0,       1, 13, 32'h0000_6001, 0, 0, 1, 1, 1, 4'b0010, 32'hA5A5_A5A5));
    vecs.push_back(mk(LSU_ST_W,  32'h0000_7000, 32'hCAFE_F00D, 32'h0,       1, 14, 32'h0000_7000, 0, 0, 1, 1, 1, 4'hF,    32'hCAFE_F00D));
    vecs.push_back(mk(LSU_LD_H,  32'h0000_8001, 32'h0,        32'h0,        1, 15, 32'h0,         0, 1, 0, 0, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_ST_H,  32'h0000_9000, 32'h1111_BEEF, 32'h0,       1, 16, 32'h0000_9000, 0, 0, 1, 1, 1, 4'b0011, 32'hBEEF_BEEF));
    vecs.push_back(mk(LSU_LD_B,  32'h0000_0100, 32'h0,        32'h0000_007F, 1, 17, 32'h0000_007F, 1, 0, 1, 1, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_NONE,  32'h5555_AAAA, 32'h0,        32'h0,        0, 18, 32'h5555_AAAA, 0, 0, 1, 0, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_ST_W,  32'h0000_A002, 32'h1234_5678, 32'h0,       1, 19, 32'h0,         0, 1, 0, 0, 0, 4'h0,    32'h0));
    vecs.push_back(mk(LSU_LD_BU, 32'h0000_0102, 32'h0,        32'h00AB_0000, 1, 20, 32'h0000_00AB, 1, 0, 1, 1, 0, 4'h0,    32'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'd0);
    chk("rst_dreq_valid", {31'h0, dreq_valid}, 32'd0);
    chk("rst_ex_ready", {31'h0, ex_ready}, 32'd1);
    chk("rst_rw_data", mem_rw_data, 32'd0);
    chk("rst_ale", {31'h0, mem_ale}, 32'd0);
    chk("rst_pc", mem_pc, 32'd0);
    rst_n = 1'b1;
    dresp_valid = 1'b1;
    dresp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dresp_valid = 1'b0;
    chk("idle_dresp_ignored", {31'h0, mem_valid}, 32'd0);

    foreach (vecs[i]) issue(vecs[i], 0, 0);

    // Bus backpressure and Writeback stall on one transaction each.
    issue(mk(LSU_ST_W, 32'h0000_B004, 32'h1357_2468, 32'h0, 1, 21, 32'h0000_B004, 0, 0, 1, 1, 1, 4'hF, 32'h1357_2468), 3, 2);
    issue(mk(LSU_LD_H, 32'h0000_C006, 32'h0, 32'h7FFE_0000, 1, 22, 32'h0000_7FFE, 1, 0, 1, 1, 0, 4'h0, 32'h0), 3, 2);
    issue(mk(LSU_NONE, 32'h0BAD_F00D, 32'h0, 32'h0, 1, 23, 32'h0BAD_F00D, 1, 0, 1, 0, 0, 4'h0, 32'h0), 0, 2);

    // Reset while waiting for a response; the late response must be dropped.
    @(negedge clk);
    ex_valid = 1'b1; ex_lsu_op = LSU_LD_W; ex_result = 32'h0000_D000; ex_rw_en = 1'b1; ex_rw_addr = 5'd3;
    chk("rst_seq_ready", {31'h0, ex_ready}, 32'd1);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("rst_seq_req", {31'h0, dreq_valid}, 32'd1);
    dreq_ready = 1'b1;
    @(posedge clk);
    #1;
    dreq_ready = 1'b0;
    @(negedge clk);
    chk("rst_seq_in_resp", {31'h0, dreq_valid | ex_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dresp_valid = 1'b1;
    dresp_rdata = 32'h1111_2222;
    @(negedge clk);
    dresp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_late_resp_mem_valid", {31'h0, mem_valid}, 32'd0);
      chk("rst_late_resp_ex_ready", {31'h0, ex_ready}, 32'd1);
      chk("rst_late_resp_dreq", {31'h0, dreq_valid}, 32'd0);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb_count", 32'(popped), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
